// File: rtl/ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory arbiter.
// Holds the arbiter FSM state encoding, the latched JTAG operation codes,
// the grant owner used for alternating arbitration, and the bit positions
// of the fields carried in the 38-bit JTAG data register (jdo).
package ocimem_pkg;

  localparam int JDO_W      = 38;
  localparam int ADDR_LSB   = 17;
  localparam int RDFLAG_BIT = 34;
  localparam int WDATA_MSB  = 34;
  localparam int WDATA_LSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RD1,
    ST_CPU_RD2,
    ST_CPU_WR,
    ST_JTAG_RD1,
    ST_JTAG_RD2,
    ST_JTAG_WR
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_LOADRD,
    OP_WR,
    OP_RD
  } jtag_op_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_JTAG
  } grant_t;

  // Only RD and WR need a RAM slot; LOAD/LOADRD first update the pointer.
  function automatic logic op_uses_ram(input jtag_op_t op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/ocimem_jtag_cmd_latch.sv
// JTAG command latch for the OCI debug-memory arbiter.
// Resolves simultaneous JTAG strobes by priority (ocimem_a > ocimem_b >
// no_action_a), captures the winning operation with its address and write
// data, and holds busy until the arbiter reports completion. Any strobe that
// is not accepted sets the sticky overrun flag.
// Ports:
//   clk, reset                 clock, async active-high reset
//   jdo                        JTAG data register (sysclk domain)
//   take_action_ocimem_a/b,
//   take_no_action_ocimem_a    1-cycle command strobes
//   op_done                    arbiter finished the latched command
//   promote_rd                 LOADRD pointer load done, continue as RD
//   busy, overrun              command held / sticky dropped-strobe flag
//   op, addr, wdata            latched command and operands
module ocimem_jtag_cmd_latch
  import ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              op_done,
  input  logic              promote_rd,
  output logic              busy,
  output logic              overrun,
  output jtag_op_t          op,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  logic     any_strobe;
  logic     multi_strobe;
  logic     accept;
  jtag_op_t new_op;
  logic     unused_jdo;

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
  assign accept       = any_strobe & ~busy;
  assign unused_jdo   = ^{jdo[JDO_W-1:WDATA_MSB+1], jdo[WDATA_LSB-1:0]};

  always_comb begin
    new_op = OP_RD;
    if (take_action_ocimem_a) begin
      new_op = jdo[RDFLAG_BIT] ? OP_LOADRD : OP_LOAD;
    end else if (take_action_ocimem_b) begin
      new_op = OP_WR;
    end
  end

  // Control: busy/overrun/op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      overrun <= 1'b0;
      op      <= OP_LOAD;
    end else begin
      if (accept) begin
        busy <= 1'b1;
        op   <= new_op;
      end else begin
        if (op_done) begin
          busy <= 1'b0;
        end
        if (promote_rd) begin
          op <= OP_RD;
        end
      end
      // Strobes while busy, and priority losers, are dropped.
      if ((any_strobe & busy) | multi_strobe) begin
        overrun <= 1'b1;
      end
    end
  end

  // Operands: captured alongside an accepted command, not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr  <= jdo[ADDR_LSB +: ADDR_W];
      wdata <= jdo[WDATA_MSB:WDATA_LSB];
    end
  end

endmodule

// File: rtl/ocimem_access_arbiter.sv
// Arbiter for the Nios II on-chip debug memory (OCI RAM).
// Shares a single-port synchronous RAM (1-cycle read latency) between the
// CPU Avalon debug_mem slave and JTAG debug commands. Owns the JTAG
// auto-increment pointer and the MonDReg readback register. Contended
// requests in IDLE alternate between requesters; an access in progress is
// never pre-empted.
// Ports:
//   clk, reset                      clock, async active-high reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a         JTAG command interface
//   MonDReg                         last JTAG read data
//   jtag_busy, jtag_overrun         JTAG command status
//   avs_*                           CPU Avalon slave
//   ram_*                           single-port RAM interface
module ocimem_access_arbiter
  import ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nx;
  grant_t            last_grant;
  grant_t            grant_nx;
  logic              grant_set;
  logic [ADDR_W-1:0] jtag_addr;
  jtag_op_t          jcmd_op;
  logic [ADDR_W-1:0] jcmd_addr;
  logic [DATA_W-1:0] jcmd_wdata;
  logic              jcmd_done;
  logic              jcmd_promote;
  logic              addr_load;
  logic              addr_bump;
  logic              mon_load;
  logic              jtag_req;
  logic              cpu_req;

  ocimem_jtag_cmd_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmd_latch (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .op_done                 (jcmd_done),
    .promote_rd              (jcmd_promote),
    .busy                    (jtag_busy),
    .overrun                 (jtag_overrun),
    .op                      (jcmd_op),
    .addr                    (jcmd_addr),
    .wdata                   (jcmd_wdata)
  );

  assign jtag_req = jtag_busy & op_uses_ram(jcmd_op);
  assign cpu_req  = avs_read | avs_write;

  // The CPU is released only in the cycle its RAM slot is serviced.
  assign avs_waitrequest = cpu_req & ~((state == ST_CPU_RD2) | (state == ST_CPU_WR));

  always_comb begin
    state_nx     = state;
    grant_set    = 1'b0;
    grant_nx     = last_grant;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_be       = 4'h0;
    avs_readdata = '0;
    jcmd_done    = 1'b0;
    jcmd_promote = 1'b0;
    addr_load    = 1'b0;
    addr_bump    = 1'b0;
    mon_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        // Pointer loads need no RAM slot and complete here.
        if (jtag_busy && (jcmd_op == OP_LOAD)) begin
          addr_load = 1'b1;
          jcmd_done = 1'b1;
        end
        if (jtag_busy && (jcmd_op == OP_LOADRD)) begin
          addr_load    = 1'b1;
          jcmd_promote = 1'b1;
        end
        if (jtag_req && (!cpu_req || (last_grant == GRANT_CPU))) begin
          grant_set = 1'b1;
          grant_nx  = GRANT_JTAG;
          state_nx  = (jcmd_op == OP_RD) ? ST_JTAG_RD1 : ST_JTAG_WR;
        end else if (cpu_req) begin
          grant_set = 1'b1;
          grant_nx  = GRANT_CPU;
          state_nx  = avs_read ? ST_CPU_RD1 : ST_CPU_WR;
        end
      end
      ST_CPU_RD1: begin
        ram_en   = 1'b1;
        ram_addr = avs_address;
        state_nx = ST_CPU_RD2;
      end
      ST_CPU_RD2: begin
        avs_readdata = ram_rdata;
        state_nx     = ST_IDLE;
      end
      ST_CPU_WR: begin
        // Writes without debugaccess are acknowledged but discarded.
        if (avs_debugaccess) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
          ram_be    = avs_byteenable;
        end
        state_nx = ST_IDLE;
      end
      ST_JTAG_RD1: begin
        ram_en   = 1'b1;
        ram_addr = jtag_addr;
        state_nx = ST_JTAG_RD2;
      end
      ST_JTAG_RD2: begin
        mon_load  = 1'b1;
        addr_bump = 1'b1;
        jcmd_done = 1'b1;
        state_nx  = ST_IDLE;
      end
      ST_JTAG_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_addr  = jtag_addr;
        ram_wdata = jcmd_wdata;
        addr_bump = 1'b1;
        jcmd_done = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_CPU;
      jtag_addr  <= '0;
      MonDReg    <= '0;
    end else begin
      state <= state_nx;
      if (grant_set) begin
        last_grant <= grant_nx;
      end
      // Pointer wraps naturally at 2^ADDR_W.
      if (addr_load) begin
        jtag_addr <= jcmd_addr;
      end else if (addr_bump) begin
        jtag_addr <= jtag_addr + ADDR_ONE;
      end
      if (mon_load) begin
        MonDReg <= ram_rdata;
      end
    end
  end

endmodule
